// File: rtl/data_memory_pkg.sv
// Shared defaults for the data/stack memory: word width, address width and depth.
package data_memory_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DEPTH_BITS = 12;
  localparam int DEF_DEPTH      = 1 << DEF_DEPTH_BITS;

endpackage

// File: rtl/data_memory.sv
// Word-addressed data/stack memory: combinational read, clocked write, async clear on rst.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DEPTH_BITS = DEF_DEPTH_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] readData,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              cs,
  input  logic              push
);

  localparam int Depth = 1 << DEPTH_BITS;

  logic [DATA_W-1:0]     mem [Depth];
  logic [DEPTH_BITS-1:0] idx;
  logic                  wr_en;
  logic                  rd_en;

  // Upper address bits alias onto the same words; they are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^address[ADDR_W-1:DEPTH_BITS];

  assign idx   = address[DEPTH_BITS-1:0];
  assign wr_en = cs & (memWrite | push);
  assign rd_en = cs & memRead & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[idx] <= writeData;
    end
  end

  // No write bypass: a same-cycle write shows up only after the edge.
  assign readData = rd_en ? mem[idx] : '0;

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory.
module tb_data_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address;
  logic [15:0] writeData;
  logic [15:0] readData;
  logic        memRead, memWrite, cs, push;

  int n_chk  = 0;
  int n_fail = 0;

  data_memory dut (
    .clk(clk), .rst(rst), .address(address), .writeData(writeData),
    .readData(readData), .memRead(memRead), .memWrite(memWrite),
    .cs(cs), .push(push)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one write (store or push) spanning a single rising edge.
  task automatic wr(input logic [31:0] a, input logic [15:0] d, input logic use_push);
    @(negedge clk);
    cs = 1'b1; address = a; writeData = d;
    memWrite = ~use_push; push = use_push; memRead = 1'b0;
    @(posedge clk); #1;
    memWrite = 1'b0; push = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [15:0] exp);
    @(negedge clk);
    cs = 1'b1; address = a; memRead = 1'b1; memWrite = 1'b0; push = 1'b0;
    #1 chk(tag, readData, exp);
    memRead = 1'b0;
  endtask

  initial begin
    rst = 1'b1; address = '0; writeData = '0;
    memRead = 1'b1; memWrite = 1'b0; cs = 1'b1; push = 1'b0;
    #2 chk("rd_in_reset", readData, 16'h0000);
    #10 rst = 1'b0;

    rd("reset_read_0x10", 32'h10, 16'h0000);

    wr(32'h5, 16'hABCD, 1'b0);
    rd("store_load_5", 32'h5, 16'hABCD);

    wr(32'hFFFF_FFFF, 16'h1234, 1'b1);
    wr(32'hFFFF_FFFE, 16'h5678, 1'b1);
    rd("push_ffffffff", 32'hFFFF_FFFF, 16'h1234);
    rd("push_fffffffe", 32'hFFFF_FFFE, 16'h5678);
    rd("alias_fff", 32'h0000_0FFF, 16'h1234);
    rd("alias_ffe", 32'h1234_5FFE, 16'h5678);

    // Chip select off: write ignored, read forced to zero.
    @(negedge clk);
    cs = 1'b0; address = 32'h3; writeData = 16'hFFFF; memWrite = 1'b1;
    @(posedge clk); #1 memWrite = 1'b0;
    rd("cs0_write_ignored", 32'h3, 16'h0000);
    @(negedge clk);
    cs = 1'b0; address = 32'h5; memRead = 1'b1;
    #1 chk("cs0_read_zero", readData, 16'h0000);
    cs = 1'b1; memRead = 1'b0;
    #1 chk("memread0_zero", readData, 16'h0000);

    // Read-during-write: old word before the edge, new word after.
    wr(32'h7, 16'h1111, 1'b0);
    @(negedge clk);
    cs = 1'b1; address = 32'h7; memRead = 1'b1; memWrite = 1'b1; writeData = 16'h2222;
    #1 chk("rdw_before_edge", readData, 16'h1111);
    @(posedge clk); #1;
    chk("rdw_after_edge", readData, 16'h2222);
    memWrite = 1'b0; memRead = 1'b0;

    // memWrite and push together: one write of writeData.
    @(negedge clk);
    cs = 1'b1; address = 32'h20; writeData = 16'h4242; memWrite = 1'b1; push = 1'b1;
    @(posedge clk); #1 memWrite = 1'b0; push = 1'b0;
    rd("both_en_20", 32'h20, 16'h4242);
    rd("both_en_21_untouched", 32'h21, 16'h0000);

    // Async reset between edges clears storage without any clock edge.
    wr(32'h9, 16'hBEEF, 1'b0);
    rd("pre_reset_9", 32'h9, 16'hBEEF);
    @(negedge clk);
    address = 32'h9; memRead = 1'b1;
    #1 rst = 1'b1;
    #1 chk("rst_read_zero", readData, 16'h0000);
    #1 rst = 1'b0;
    #1 chk("async_clear_9", readData, 16'h0000);
    address = 32'h5;
    #0.5 chk("async_clear_5", readData, 16'h0000);
    memRead = 1'b0;

    // Write edge coinciding with reset assertion is lost.
    @(negedge clk);
    address = 32'hA; writeData = 16'h5555; memWrite = 1'b1;
    @(posedge clk);
    rst = 1'b1;
    #1 memWrite = 1'b0;
    chk("write_during_rst_rd", readData, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    rd("coincident_write_lost", 32'hA, 16'h0000);

    // First write after reset release lands on the next edge.
    wr(32'hB, 16'h00C3, 1'b0);
    rd("post_reset_write", 32'hB, 16'h00C3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
